// File: rtl/grouper_pkg.sv
// Shared definitions for grouper/ungrouper: end-of-token marker and decoder states.
// Vocab SRAM format: entries packed back-to-back from address 0, each terminated
// by EOT. Token ID k is the k-th entry, so k equals the number of EOTs before it.
// An EOT sitting at an entry start is an empty entry.
package grouper_pkg;

  localparam int EOT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_TOK,
    ST_SCAN,
    ST_COPY,
    ST_DONE
  } ug_state_t;

endpackage

// File: rtl/ungrouper_vocab_locator.sv
// Purpose: streams vocab reads from address 0 and counts EOTs until entry `id` starts.
// Latency: found/not_found pulse one cycle after the matching address is read; one read per cycle.
// Backpressure: none; busy from start until found/not_found.
// Ports: start/id in; voc_addr out, voc_dout in; found/not_found/start_addr out.
module vocab_locator
  import grouper_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] id,
  output logic [ADDR_WIDTH-1:0] voc_addr,
  input  logic [DATA_WIDTH-1:0] voc_dout,
  output logic                  found,
  output logic                  not_found,
  output logic [ADDR_WIDTH-1:0] start_addr
);

  localparam logic [DATA_WIDTH-1:0] EOT_W = DATA_WIDTH'(EOT);

  logic                  busy;
  logic [ADDR_WIDTH-1:0] addr;     // next address to issue
  logic [ADDR_WIDTH-1:0] ev_addr;  // address whose data is on voc_dout now
  logic                  ev_vld;
  logic [DATA_WIDTH-1:0] cnt;      // EOTs seen strictly before ev_addr

  // Entry id starts at the first evaluated address preceded by exactly id EOTs.
  // Reaching the last address without that means the entry does not exist.
  always_comb begin
    found      = busy && ev_vld && (cnt == id);
    not_found  = busy && ev_vld && (cnt != id) && (ev_addr == '1);
    start_addr = ev_addr;
    voc_addr   = addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      addr    <= '0;
      ev_addr <= '0;
      ev_vld  <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      addr   <= '0;
      ev_vld <= 1'b0;
      cnt    <= '0;
    end else if (busy) begin
      if (found || not_found) begin
        busy   <= 1'b0;
        ev_vld <= 1'b0;
      end else begin
        addr    <= addr + 1'b1;
        ev_addr <= addr;
        ev_vld  <= 1'b1;
        if (ev_vld && voc_dout == EOT_W) cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ungrouper.sv
// Purpose: detokenizer; for each token ID copies its vocab entry bytes into output SRAM.
// Latency: per token 2 cycles fetch + scan (up to D+1) + one cycle per byte + 2; done held while cs=1.
// Backpressure: none; single-cycle writes, SRAMs assumed always ready.
// Ports: cs/n_tok start a job; tok_*, voc_* read SRAMs (1-cycle latency); out_* write SRAM;
//        out_len/done/err report progress and result.
module ungrouper
  import grouper_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic [ADDR_WIDTH:0]   n_tok,
  output logic [ADDR_WIDTH-1:0] tok_addr,
  input  logic [DATA_WIDTH-1:0] tok_dout,
  output logic [ADDR_WIDTH-1:0] voc_addr,
  input  logic [DATA_WIDTH-1:0] voc_dout,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic                  out_we,
  output logic [ADDR_WIDTH:0]   out_len,
  output logic                  done,
  output logic                  err
);

  localparam logic [DATA_WIDTH-1:0] EOT_W = DATA_WIDTH'(EOT);
  localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

  ug_state_t state, state_nxt;

  logic [ADDR_WIDTH:0]   n_lat, ti, out_len_q;
  logic [DATA_WIDTH-1:0] id_q;
  logic [ADDR_WIDTH-1:0] rd_addr, cp_ev_addr;
  logic                  cp_vld, err_q;
  logic                  loc_start, loc_found, loc_nf;
  logic [ADDR_WIDTH-1:0] loc_addr, loc_start_addr;
  logic                  wr, ovf, ent_end, last_tok;

  vocab_locator #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_loc (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (loc_start),
    .id         (id_q),
    .voc_addr   (loc_addr),
    .voc_dout   (voc_dout),
    .found      (loc_found),
    .not_found  (loc_nf),
    .start_addr (loc_start_addr)
  );

  assign last_tok = ((ti + 1'b1) == n_lat);
  assign out_len  = out_len_q;
  assign err      = err_q;
  assign done     = (state == ST_DONE);
  assign tok_addr = ti[ADDR_WIDTH-1:0];
  assign out_we   = wr;
  assign out_addr = wr ? out_len_q[ADDR_WIDTH-1:0] : '0;
  assign out_din  = wr ? voc_dout : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    loc_start = 1'b0;
    wr        = 1'b0;
    ovf       = 1'b0;
    ent_end   = 1'b0;
    voc_addr  = '0;
    case (state)
      ST_IDLE: if (cs) state_nxt = (n_tok == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH: state_nxt = ST_WAIT_TOK;
      ST_WAIT_TOK: begin
        // Entry 0 always starts at address 0, so no scan is needed.
        if (tok_dout == '0) begin
          state_nxt = ST_COPY;
        end else begin
          loc_start = 1'b1;
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        voc_addr = loc_addr;
        if (loc_found)   state_nxt = ST_COPY;
        else if (loc_nf) state_nxt = ST_DONE;
      end
      ST_COPY: begin
        voc_addr = rd_addr;
        if (cp_vld) begin
          if (voc_dout != EOT_W && out_len_q == DEPTH) begin
            ovf       = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            wr = (voc_dout != EOT_W);
            // A byte at the last address without EOT still closes the entry.
            if (voc_dout == EOT_W || cp_ev_addr == '1) begin
              ent_end   = 1'b1;
              state_nxt = last_tok ? ST_DONE : ST_FETCH;
            end
          end
        end
      end
      ST_DONE: if (!cs) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lat      <= '0;
      ti         <= '0;
      out_len_q  <= '0;
      err_q      <= 1'b0;
      id_q       <= '0;
      rd_addr    <= '0;
      cp_ev_addr <= '0;
      cp_vld     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cs) begin
            n_lat     <= n_tok;
            ti        <= '0;
            out_len_q <= '0;
            err_q     <= 1'b0;
          end
        end
        ST_WAIT_TOK: begin
          id_q    <= tok_dout;
          rd_addr <= '0;
          cp_vld  <= 1'b0;
        end
        ST_SCAN: begin
          if (loc_found) begin
            rd_addr <= loc_start_addr;
            cp_vld  <= 1'b0;
          end
          if (loc_nf) err_q <= 1'b1;
        end
        ST_COPY: begin
          rd_addr    <= rd_addr + 1'b1;
          cp_ev_addr <= rd_addr;
          cp_vld     <= 1'b1;
          if (wr)      out_len_q <= out_len_q + 1'b1;
          if (ovf)     err_q     <= 1'b1;
          if (ent_end) ti        <= ti + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ungrouper.sv
module tb_ungrouper;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs = 1'b0;
  logic [AW:0]   n_tok = '0;
  logic [AW-1:0] tok_addr, voc_addr, out_addr;
  logic [DW-1:0] tok_dout, voc_dout, out_din;
  logic          out_we, done, err;
  logic [AW:0]   out_len;

  logic [DW-1:0] tok_mem [D];
  logic [DW-1:0] voc_mem [D];
  logic [DW-1:0] out_mem [D];
  logic          clr_out = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int n_wr = 0;
  int exp_addr[$];
  int exp_data[$];
  int exp_stream[$];
  int exp_len;
  bit exp_err;
  bit chk_en = 1'b0;

  ungrouper #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .n_tok(n_tok),
    .tok_addr(tok_addr), .tok_dout(tok_dout),
    .voc_addr(voc_addr), .voc_dout(voc_dout),
    .out_addr(out_addr), .out_din(out_din), .out_we(out_we),
    .out_len(out_len), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM models: one-cycle read latency, single-cycle write.
  always @(posedge clk) begin
    tok_dout <= tok_mem[tok_addr];
    voc_dout <= voc_mem[voc_addr];
    if (clr_out) begin
      for (int i = 0; i < D; i++) out_mem[i] <= 8'hEE;
    end else if (out_we) begin
      out_mem[out_addr] <= out_din;
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Every write pulse must match the next byte of the expected stream.
  always @(negedge clk) begin
    if (rst_n && chk_en && out_we) begin
      n_wr++;
      if (exp_addr.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        chk("wr_addr", int'(out_addr), exp_addr.pop_front());
        chk("wr_data", int'(out_din), exp_data.pop_front());
      end
    end
  end

  // Reference: list entry start addresses, then concatenate entries per token.
  task automatic build_model(input int n);
    int starts[$];
    int len;
    int a;
    int id;
    bit e;
    bit fin;
    exp_addr.delete();
    exp_data.delete();
    exp_stream.delete();
    starts.push_back(0);
    for (int k = 0; k < D - 1; k++) if (voc_mem[k] == 0) starts.push_back(k + 1);
    len = 0;
    e = 0;
    for (int t = 0; t < n && !e; t++) begin
      id = int'(tok_mem[t]);
      if (id >= starts.size()) begin
        e = 1;
      end else begin
        a = starts[id];
        fin = 0;
        while (!fin) begin
          if (voc_mem[a] == 0) begin
            fin = 1;
          end else if (len == D) begin
            e = 1;
            fin = 1;
          end else begin
            exp_addr.push_back(len);
            exp_data.push_back(int'(voc_mem[a]));
            exp_stream.push_back(int'(voc_mem[a]));
            len++;
            if (a == D - 1) fin = 1;
            else a++;
          end
        end
      end
    end
    exp_len = len;
    exp_err = e;
  endtask

  task automatic run_job(input int n, input string nm, output int cyc, output int nwr);
    int base;
    build_model(n);
    clr_out = 1'b1;
    @(posedge clk); #1;
    clr_out = 1'b0;
    base = n_wr;
    chk_en = 1'b1;
    n_tok = n[AW:0];
    cs = 1'b1;
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_done"}, int'(done), 1);
    chk({nm, "_out_len"}, int'(out_len), exp_len);
    chk({nm, "_err"}, int'(err), int'(exp_err));
    chk({nm, "_pending"}, exp_addr.size(), 0);
    for (int i = 0; i < exp_len; i++) chk({nm, "_mem"}, int'(out_mem[i]), exp_stream[i]);
    nwr = n_wr - base;
  endtask

  task automatic finish_job(input string nm);
    cs = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_done_clr"}, int'(done), 0);
  endtask

  task automatic load_basic();
    logic [DW-1:0] v [9];
    v = '{8'h41, 8'h42, 8'h00, 8'h43, 8'h00, 8'h44, 8'h45, 8'h46, 8'h00};
    for (int i = 0; i < D; i++) begin
      voc_mem[i] = (i < 9) ? v[i] : 8'h00;
      tok_mem[i] = 8'h00;
    end
    tok_mem[0] = 8'd2;
    tok_mem[1] = 8'd0;
    tok_mem[2] = 8'd1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int nwr;
    int lit [6];
    bit seen;
    lit = '{'h44, 'h45, 'h46, 'h41, 'h42, 'h43};
    load_basic();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_out_len", int'(out_len), 0);
    chk("rst_out_we", int'(out_we), 0);
    chk("rst_voc_addr", int'(voc_addr), 0);
    chk("rst_tok_addr", int'(tok_addr), 0);
    rst_n = 1'b1;

    // Basic decode plus literal pins, then handshake hold
    run_job(3, "basic", cyc, nwr);
    chk("basic_model_len", exp_len, 6);
    chk("basic_lit_len", int'(out_len), 6);
    chk("basic_lit_err", int'(err), 0);
    for (int i = 0; i < 6; i++) chk("basic_lit_mem", int'(out_mem[i]), lit[i]);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_done", int'(done), 1);
      chk("hold_len", int'(out_len), 6);
      chk("hold_we", int'(out_we), 0);
    end
    finish_job("basic");
    run_job(3, "rerun", cyc, nwr);
    chk("rerun_lit_len", int'(out_len), 6);
    finish_job("rerun");

    // Empty input
    run_job(0, "empty", cyc, nwr);
    chk("empty_latency_le2", int'(cyc <= 2), 1);
    chk("empty_writes", nwr, 0);
    chk("empty_lit_len", int'(out_len), 0);
    finish_job("empty");

    // ID not found
    for (int i = 0; i < D; i++) voc_mem[i] = 8'h55;
    tok_mem[0] = 8'd1;
    run_job(1, "notfound", cyc, nwr);
    chk("notfound_lit_err", int'(err), 1);
    chk("notfound_lit_len", int'(out_len), 0);
    finish_job("notfound");

    // Overflow: six copies of a three-byte entry
    load_basic();
    for (int i = 0; i < 6; i++) tok_mem[i] = 8'd2;
    run_job(6, "ovf", cyc, nwr);
    chk("ovf_lit_writes", nwr, 16);
    chk("ovf_lit_len", int'(out_len), 16);
    chk("ovf_lit_err", int'(err), 1);
    finish_job("ovf");

    // Reset during COPY
    load_basic();
    build_model(3);
    chk_en = 1'b1;
    n_tok = 3;
    cs = 1'b1;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (out_we) seen = 1;
    end
    chk("midrst_write_seen", int'(seen), 1);
    #1;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_we", int'(out_we), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_len", int'(out_len), 0);
    chk("midrst_addr", int'(out_addr), 0);
    chk("midrst_din", int'(out_din), 0);
    chk("midrst_voc_addr", int'(voc_addr), 0);
    cs = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_job(3, "after_rst", cyc, nwr);
    chk("after_rst_lit_len", int'(out_len), 6);
    finish_job("after_rst");

    // Randomized jobs
    for (int it = 0; it < 30; it++) begin
      int n;
      for (int i = 0; i < D; i++) begin
        voc_mem[i] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        tok_mem[i] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 5));
      end
      n = $urandom_range(0, D);
      run_job(n, "rand", cyc, nwr);
      finish_job("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
